// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage bundle: everything that crosses the pipeline register from decode to execute.
// The producer uses the master modport; the consumer uses the slave modport.
interface id_ex_pipe_reg_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ALU_OP_W = 2
);
  logic                valid;
  logic [DATA_W-1:0]   pc_plus4;
  logic [DATA_W-1:0]   rs_data;
  logic [DATA_W-1:0]   rt_data;
  logic [DATA_W-1:0]   imm;
  logic [4:0]          rs_addr;
  logic [4:0]          rt_addr;
  logic [4:0]          rd_addr;
  logic                reg_write;
  logic                mem_to_reg;
  logic                mem_read;
  logic                mem_write;
  logic                branch;
  logic                alu_src;
  logic                reg_dst;
  logic [ALU_OP_W-1:0] alu_op;

  modport master (
    output valid, pc_plus4, rs_data, rt_data, imm, rs_addr, rt_addr, rd_addr,
           reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op
  );

  modport slave (
    input  valid, pc_plus4, rs_data, rt_data, imm, rs_addr, rt_addr, rd_addr,
           reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall (hold) and flush (bubble), flush taking priority.
// Optional saturating bubble counter enabled by defining IDEX_BUBBLE_CNT_EN.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ALU_OP_W = 2
`ifdef IDEX_BUBBLE_CNT_EN
  , parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  id_ex_pipe_reg_if.slave        id_i,
  id_ex_pipe_reg_if.master       ex_o
`ifdef IDEX_BUBBLE_CNT_EN
  , output logic [CNT_W-1:0]     bubble_cnt_o
`endif
);

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   pc_plus4;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [DATA_W-1:0]   imm;
    logic [4:0]          rs_addr;
    logic [4:0]          rt_addr;
    logic [4:0]          rd_addr;
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                alu_src;
    logic                reg_dst;
    logic [ALU_OP_W-1:0] alu_op;
  } stage_t;

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      stage_d = '0;
    end else if (!stall_i) begin
      stage_d.valid      = id_i.valid;
      stage_d.pc_plus4   = id_i.pc_plus4;
      stage_d.rs_data    = id_i.rs_data;
      stage_d.rt_data    = id_i.rt_data;
      stage_d.imm        = id_i.imm;
      stage_d.rs_addr    = id_i.rs_addr;
      stage_d.rt_addr    = id_i.rt_addr;
      stage_d.rd_addr    = id_i.rd_addr;
      // An invalid slot must never carry live control into EX.
      stage_d.reg_write  = id_i.valid & id_i.reg_write;
      stage_d.mem_to_reg = id_i.valid & id_i.mem_to_reg;
      stage_d.mem_read   = id_i.valid & id_i.mem_read;
      stage_d.mem_write  = id_i.valid & id_i.mem_write;
      stage_d.branch     = id_i.valid & id_i.branch;
      stage_d.alu_src    = id_i.valid & id_i.alu_src;
      stage_d.reg_dst    = id_i.valid & id_i.reg_dst;
      stage_d.alu_op     = id_i.valid ? id_i.alu_op : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign ex_o.valid      = stage_q.valid;
  assign ex_o.pc_plus4   = stage_q.pc_plus4;
  assign ex_o.rs_data    = stage_q.rs_data;
  assign ex_o.rt_data    = stage_q.rt_data;
  assign ex_o.imm        = stage_q.imm;
  assign ex_o.rs_addr    = stage_q.rs_addr;
  assign ex_o.rt_addr    = stage_q.rt_addr;
  assign ex_o.rd_addr    = stage_q.rd_addr;
  assign ex_o.reg_write  = stage_q.reg_write;
  assign ex_o.mem_to_reg = stage_q.mem_to_reg;
  assign ex_o.mem_read   = stage_q.mem_read;
  assign ex_o.mem_write  = stage_q.mem_write;
  assign ex_o.branch     = stage_q.branch;
  assign ex_o.alu_src    = stage_q.alu_src;
  assign ex_o.reg_dst    = stage_q.reg_dst;
  assign ex_o.alu_op     = stage_q.alu_op;

`ifdef IDEX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bubble_cnt_q <= '0;
    else       bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (bubble counter checked when IDEX_BUBBLE_CNT_EN is defined).
module tb_id_ex_pipe_reg;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic stall_i = 1'b0;
  logic flush_i = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  id_ex_pipe_reg_if #(.DATA_W(32), .ALU_OP_W(2)) id_if ();
  id_ex_pipe_reg_if #(.DATA_W(32), .ALU_OP_W(2)) ex_if ();

`ifdef IDEX_BUBBLE_CNT_EN
  logic [1:0] bubble_cnt_o;
`endif

  id_ex_pipe_reg #(
    .DATA_W(32),
    .ALU_OP_W(2)
`ifdef IDEX_BUBBLE_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .id_i    (id_if.slave),
    .ex_o    (ex_if.master)
`ifdef IDEX_BUBBLE_CNT_EN
    , .bubble_cnt_o (bubble_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_all(input logic v, input logic [31:0] base);
    id_if.valid      = v;
    id_if.pc_plus4   = base + 32'h4;
    id_if.rs_data    = base + 32'h11;
    id_if.rt_data    = base + 32'h22;
    id_if.imm        = base + 32'h33;
    id_if.rs_addr    = 5'd1;
    id_if.rt_addr    = 5'd2;
    id_if.rd_addr    = 5'd3;
    id_if.reg_write  = 1'b1;
    id_if.mem_to_reg = 1'b1;
    id_if.mem_read   = 1'b1;
    id_if.mem_write  = 1'b1;
    id_if.branch     = 1'b1;
    id_if.alu_src    = 1'b1;
    id_if.reg_dst    = 1'b1;
    id_if.alu_op     = 2'b11;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"},    64'(ex_if.valid), 64'd0);
    check({tag, ".ctrl"},     64'({ex_if.reg_write, ex_if.mem_to_reg, ex_if.mem_read, ex_if.mem_write,
                                   ex_if.branch, ex_if.alu_src, ex_if.reg_dst}), 64'd0);
    check({tag, ".alu_op"},   64'(ex_if.alu_op), 64'd0);
    check({tag, ".data"},     64'(ex_if.pc_plus4 | ex_if.rs_data | ex_if.rt_data | ex_if.imm), 64'd0);
    check({tag, ".addr"},     64'({ex_if.rs_addr, ex_if.rt_addr, ex_if.rd_addr}), 64'd0);
  endtask

  initial begin
    drive_all(1'b1, 32'h1000_0000);
    #12;
    rst_i = 1'b0;

    // Reset asserted between edges clears outputs immediately
    tick();
    check("rst_pre.valid", 64'(ex_if.valid), 64'd1);
    check("rst_pre.imm",   64'(ex_if.imm), 64'h1000_0033);
    #1 rst_i = 1'b1;
    #1;
    check_bubble("async_rst");
    #2 rst_i = 1'b0;

    // Load
    drive_all(1'b1, 32'h0);
    id_if.imm = 32'hFFFF_FFF6; id_if.rs_data = 32'h0000_0005; id_if.rd_addr = 5'd3;
    id_if.reg_write = 1'b1; id_if.alu_op = 2'b10;
    check("load_before.imm", 64'(ex_if.imm), 64'd0);
    tick();
    check("load.imm",       64'(ex_if.imm), 64'hFFFF_FFF6);
    check("load.rs_data",   64'(ex_if.rs_data), 64'h5);
    check("load.rd_addr",   64'(ex_if.rd_addr), 64'd3);
    check("load.reg_write", 64'(ex_if.reg_write), 64'd1);
    check("load.alu_op",    64'(ex_if.alu_op), 64'd2);
    check("load.valid",     64'(ex_if.valid), 64'd1);
    check("load.pc",        64'(ex_if.pc_plus4), 64'h4);

    // Stall: A held for 3 edges, B appears after release
    id_if.imm = 32'h0000_0004;
    tick();
    check("stall_A.imm", 64'(ex_if.imm), 64'h4);
    stall_i = 1'b1;
    id_if.imm = 32'h1234_5678; id_if.rt_data = 32'hAAAA_5555; id_if.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold.imm",   64'(ex_if.imm), 64'h4);
      check("stall_hold.valid", 64'(ex_if.valid), 64'd1);
      check("stall_hold.rt",    64'(ex_if.rt_data), 64'h22);
    end
    stall_i = 1'b0;
    id_if.valid = 1'b1;
    tick();
    check("stall_rel.imm", 64'(ex_if.imm), 64'h1234_5678);
    check("stall_rel.rt",  64'(ex_if.rt_data), 64'hAAAA_5555);

    // Flush with stall: bubble wins
    flush_i = 1'b1; stall_i = 1'b1;
    tick();
    check_bubble("flush_stall");
`ifdef IDEX_BUBBLE_CNT_EN
    check("flush_stall.cnt", 64'(bubble_cnt_o), 64'd1);
`endif
    flush_i = 1'b0; stall_i = 1'b0;

    // Invalid load gates control, passes data
    drive_all(1'b0, 32'h2000_0000);
    id_if.rt_data = 32'hDEAD_BEEF;
    tick();
    check("inv.valid",  64'(ex_if.valid), 64'd0);
    check("inv.ctrl",   64'({ex_if.reg_write, ex_if.mem_to_reg, ex_if.mem_read, ex_if.mem_write,
                             ex_if.branch, ex_if.alu_src, ex_if.reg_dst}), 64'd0);
    check("inv.alu_op", 64'(ex_if.alu_op), 64'd0);
    check("inv.rt",     64'(ex_if.rt_data), 64'hDEAD_BEEF);
    check("inv.imm",    64'(ex_if.imm), 64'h2000_0033);

    // Reset mid-stall: stall has no effect, outputs cleared
    drive_all(1'b1, 32'h3000_0000);
    tick();
    stall_i = 1'b1;
    #1 rst_i = 1'b1;
    #1;
    check_bubble("rst_stall");
    #2 rst_i = 1'b0;
    tick();
    check("rst_stall_rel.imm", 64'(ex_if.imm), 64'd0);
    stall_i = 1'b0;
    tick();
    check("post_rst_load.imm", 64'(ex_if.imm), 64'h3000_0033);

`ifdef IDEX_BUBBLE_CNT_EN
    begin
      logic [1:0] exp_cnt [5];
      exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
      check("cnt_after_rst", 64'(bubble_cnt_o), 64'd0);
      flush_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        check("cnt_seq", 64'(bubble_cnt_o), 64'(exp_cnt[i]));
      end
      flush_i = 1'b0;
      #1 rst_i = 1'b1;
      #1;
      check("cnt_async_rst", 64'(bubble_cnt_o), 64'd0);
      #2 rst_i = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
